// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// The requester drives the master side and the adder implements the slave side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin computed LSB first through a single
// full-adder cell, one bit per clock, with valid/ready handshakes on both sides.
module FA (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c;
  assign c_out = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             step;
  logic             last;

  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_c;

  FA fa_u (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry_q),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // Partial sum bits accumulate from the top; the new bit lands in the MSB.
  assign sum_next = {fa_s, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST_BIT) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (step) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_next[WIDTH-1:1];
      carry_q <= fa_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      // Visible result only changes on DONE entry, so the previous one survives RUN.
      if (last) begin
        sum_q  <= sum_next;
        cout_q <= fa_c;
        ovf_q  <= carry_q ^ fa_c;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input logic [7:0] prev);
    int n;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    bus.cin      = ~ci;
    chk("busy_after_accept", bus.in_ready, 1'b0);
    tick;
    tick;
    chk("sum_kept_mid_run", bus.sum, prev);
    n = 2;
    while (!bus.out_valid && n < 40) begin
      tick;
      n++;
    end
    chk("latency", n, W);
    chk("sum", bus.sum, es);
    chk("cout", bus.cout, ec);
    chk("overflow", bus.overflow, eo);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("ready_after_done", bus.in_ready, 1'b1);
    chk("valid_after_done", bus.out_valid, 1'b0);
    chk("sum_kept_idle", bus.sum, es);
  endtask

  initial begin
    int first;
    int acc;
    int m;
    logic pre;
    logic seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 8'h00);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 8'h00);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h8D);
    run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8'h00);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);

    // Backpressure: hold result, with stray in_valid pulses
    bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    m = 0;
    while (!bus.out_valid && m < 40) begin
      tick;
      m++;
    end
    chk("bp_latency", m, W);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a        = 8'h11;
      bus.b        = 8'h22;
      tick;
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_sum", bus.sum, 8'h8D);
      chk("bp_cout", bus.cout, 1'b0);
      chk("bp_overflow", bus.overflow, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("bp_release_ready", bus.in_ready, 1'b1);

    // Back-to-back with in_valid held high
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    bus.a = 8'hC0; bus.b = 8'h50; bus.cin = 1'b1;
    first = -1;
    acc   = -1;
    for (int n = 1; n <= 40; n++) begin
      pre = bus.in_ready;
      tick;
      if (bus.out_valid && first < 0) begin
        first = n;
        chk("b2b_sum1", bus.sum, 8'h46);
        chk("b2b_cout1", bus.cout, 1'b0);
        chk("b2b_ovf1", bus.overflow, 1'b0);
      end
      if (pre) begin
        acc = n;
        break;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_latency1", first, W);
    chk("b2b_issue_gap", acc, W + 2);
    m = 0;
    while (!bus.out_valid && m < 40) begin
      tick;
      m++;
    end
    chk("b2b_latency2", m, W);
    chk("b2b_sum2", bus.sum, 8'h11);
    chk("b2b_cout2", bus.cout, 1'b1);
    chk("b2b_ovf2", bus.overflow, 1'b0);
    tick;
    bus.out_ready = 1'b0;
    chk("b2b_idle", bus.in_ready, 1'b1);

    // Reset three cycles into RUN aborts the request
    bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_sum", bus.sum, 8'h00);
    chk("abort_cout", bus.cout, 1'b0);
    chk("abort_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
